counter_sched: RTL

- Time-slice scheduler for the shared loadable up-counter (cen/wen/dat in, posedge count out).
- NREQ requesters each ask for an interval of len[i] clock cycles.
- The block arbitrates round-robin, grants one requester at a time, clears the counter, enables counting until the requested length is reached, then pulses done to the winner.
- Sits beside the counter instance; drives its control inputs and watches its posedge output.

---
 rtl/counter_sched_pkg.sv | 20 ++
 rtl/counter_sched_rr_pick.sv | 31 +++
 rtl/counter_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter time-slice scheduler.
// Imported by the scheduler top and its round-robin picker.
package counter_sched_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  localparam int IDX_W     = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/counter_sched_rr_pick.sv
// Rotate-priority encoder: first set req bit after ptr, modulo NREQ.
// Purely combinational.
module counter_sched_rr_pick
  import counter_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = IDX_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int j;

  // Walk from furthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin time-slice scheduler driving a shared loadable up-counter.
// Grants one requester, clears the counter, counts len cycles, pulses done.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_cen,
  output logic                  cnt_wen,
  output logic [WIDTH-1:0]      cnt_dat,
  input  logic [WIDTH-1:0]      cnt_val
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  counter_sched_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_d     = rr_q;
    target_d = target_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          g_d      = pick_idx;
          target_d = len[int'(pick_idx)*WIDTH +: WIDTH];
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[g_q]) begin
          rr_d    = g_q;
          state_d = S_IDLE;
        end else if (target_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Requester dropping out wins over completion on the same cycle.
        if (!req[g_q]) begin
          rr_d    = g_q;
          state_d = S_IDLE;
        end else if (cnt_val == target_q - WIDTH'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_d    = g_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      rr_q     <= IW'(NREQ - 1);
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
      target_q <= target_d;
    end
  end

  logic [NREQ-1:0] g_oh;

  always_comb begin
    g_oh    = NREQ'(onehot(int'(g_q)));
    busy    = (state_q != S_IDLE);
    gnt     = busy ? g_oh : '0;
    done    = (state_q == S_DONE) ? g_oh : '0;
    cnt_wen = (state_q == S_LOAD);
    cnt_cen = (state_q == S_RUN);
    cnt_dat = '0;
  end

endmodule
